// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its command sequencer: opcode values,
// command field widths and the output-slot state encoding.
package alu_pkg;

  localparam int CTRL_W    = 3;
  localparam int ALU_WIDTH = 4;
  localparam int CMD_W     = 2 * ALU_WIDTH + CTRL_W;

  localparam logic [CTRL_W-1:0] OP_ADD  = 3'd0;
  localparam logic [CTRL_W-1:0] OP_SUB  = 3'd1;
  localparam logic [CTRL_W-1:0] OP_MUL  = 3'd2;
  localparam logic [CTRL_W-1:0] OP_NAND = 3'd3;
  localparam logic [CTRL_W-1:0] OP_NOR  = 3'd4;
  localparam logic [CTRL_W-1:0] OP_LAST = OP_NOR;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Opcodes above OP_LAST have no ALU meaning and are flagged instead of computed.
  function automatic logic op_is_legal(input logic [CTRL_W-1:0] ctrl);
    return (ctrl <= OP_LAST);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous DEPTH-entry command FIFO with occupancy count; head is read
// combinationally so the ALU sees the oldest command without a read cycle.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int W     = CMD_W,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic          push, pop;

  assign o_full  = (count_q == LW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign push    = i_push && !o_full;
  assign pop     = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_data  = mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, drives the FIFO head onto the ALU and captures its
// combinational result into a single registered output slot with valid/ready.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic [WIDTH-1:0]       i_cmd_op1,
  input  logic [WIDTH-1:0]       i_cmd_op2,
  input  logic [CTRL_W-1:0]      i_cmd_ctrl,
  output logic [WIDTH-1:0]       o_alu_op1,
  output logic [WIDTH-1:0]       o_alu_op2,
  output logic [CTRL_W-1:0]      o_alu_ctrl,
  input  logic [2*WIDTH-1:0]     i_alu_data,
  output logic                   o_res_valid,
  input  logic                   i_res_ready,
  output logic [2*WIDTH-1:0]     o_res_data,
  output logic [CTRL_W-1:0]      o_res_ctrl,
  output logic                   o_res_err,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int CW = 2 * WIDTH + CTRL_W;

  logic [CW-1:0]       head;
  logic                fifo_full, fifo_empty;
  logic                cap;
  logic [WIDTH-1:0]    head_op1, head_op2;
  logic [CTRL_W-1:0]   head_ctrl;

  slot_state_e         state_q, state_d;
  logic [2*WIDTH-1:0]  res_data_q, res_data_d;
  logic [CTRL_W-1:0]   res_ctrl_q, res_ctrl_d;
  logic                res_err_q, res_err_d;

  alu_cmd_fifo #(
    .W     (CW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_cmd_valid),
    .i_data  ({i_cmd_op1, i_cmd_op2, i_cmd_ctrl}),
    .i_pop   (cap),
    .o_data  (head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (o_level)
  );

  assign o_cmd_ready = !fifo_full;
  assign head_op1    = head[CW-1 -: WIDTH];
  assign head_op2    = head[CW-1-WIDTH -: WIDTH];
  assign head_ctrl   = head[CTRL_W-1:0];

  // An empty FIFO presents zeros so the ALU never sees stale or undefined operands.
  assign o_alu_op1  = fifo_empty ? '0 : head_op1;
  assign o_alu_op2  = fifo_empty ? '0 : head_op2;
  assign o_alu_ctrl = fifo_empty ? '0 : head_ctrl;

  always_comb begin
    state_d    = state_q;
    res_data_d = res_data_q;
    res_ctrl_d = res_ctrl_q;
    res_err_d  = res_err_q;
    cap        = !fifo_empty && ((state_q == SLOT_EMPTY) || i_res_ready);

    if (cap) begin
      res_ctrl_d = head_ctrl;
      if (op_is_legal(head_ctrl)) begin
        res_data_d = i_alu_data;
        res_err_d  = 1'b0;
      end else begin
        res_data_d = '0;
        res_err_d  = 1'b1;
      end
    end

    case (state_q)
      SLOT_EMPTY: if (cap) state_d = SLOT_FULL;
      SLOT_FULL:  if (i_res_ready && !cap) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= SLOT_EMPTY;
      res_data_q <= '0;
      res_ctrl_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      res_data_q <= res_data_d;
      res_ctrl_q <= res_ctrl_d;
      res_err_q  <= res_err_d;
    end
  end

  assign o_res_valid = (state_q == SLOT_FULL);
  assign o_res_data  = res_data_q;
  assign o_res_ctrl  = res_ctrl_q;
  assign o_res_err   = res_err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed scenarios plus a random
// run, all compared against a queue-based model of the sequencer and ALU.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [WIDTH-1:0]  op1;
    logic [WIDTH-1:0]  op2;
    logic [CTRL_W-1:0] ctrl;
  } cmd_t;

  logic                i_clk = 1'b0;
  logic                i_rst_n = 1'b0;
  logic                i_cmd_valid = 1'b0;
  logic                o_cmd_ready;
  logic [WIDTH-1:0]    i_cmd_op1 = '0;
  logic [WIDTH-1:0]    i_cmd_op2 = '0;
  logic [CTRL_W-1:0]   i_cmd_ctrl = '0;
  logic [WIDTH-1:0]    o_alu_op1;
  logic [WIDTH-1:0]    o_alu_op2;
  logic [CTRL_W-1:0]   o_alu_ctrl;
  logic [2*WIDTH-1:0]  i_alu_data;
  logic                o_res_valid;
  logic                i_res_ready = 1'b0;
  logic [2*WIDTH-1:0]  o_res_data;
  logic [CTRL_W-1:0]   o_res_ctrl;
  logic                o_res_err;
  logic [LW-1:0]       o_level;

  int nvec = 0;
  int nfail = 0;

  // Model state: pending commands and the result slot contents.
  cmd_t               m_q[$];
  logic               m_v;
  logic [2*WIDTH-1:0] m_data;
  logic [CTRL_W-1:0]  m_ctrl;
  logic               m_err;

  always #5 i_clk = ~i_clk;

  alu_cmd_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_op1   (i_cmd_op1),
    .i_cmd_op2   (i_cmd_op2),
    .i_cmd_ctrl  (i_cmd_ctrl),
    .o_alu_op1   (o_alu_op1),
    .o_alu_op2   (o_alu_op2),
    .o_alu_ctrl  (o_alu_ctrl),
    .i_alu_data  (i_alu_data),
    .o_res_valid (o_res_valid),
    .i_res_ready (i_res_ready),
    .o_res_data  (o_res_data),
    .o_res_ctrl  (o_res_ctrl),
    .o_res_err   (o_res_err),
    .o_level     (o_level)
  );

  // Arithmetic meaning of each opcode; illegal codes return a marker the
  // sequencer must never pass through.
  function automatic logic [2*WIDTH-1:0] alu_ref(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [CTRL_W-1:0] c);
    logic [WIDTH-1:0] n;
    case (c)
      OP_ADD:  begin n = a + b;     return {{WIDTH{1'b0}}, n}; end
      OP_SUB:  begin n = a - b;     return {{WIDTH{1'b0}}, n}; end
      OP_MUL:  return {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      OP_NAND: begin n = ~(a & b);  return {{WIDTH{1'b0}}, n}; end
      OP_NOR:  begin n = ~(a | b);  return {{WIDTH{1'b0}}, n}; end
      default: return 8'hA5;
    endcase
  endfunction

  function automatic logic [2*WIDTH-1:0] exp_result(input cmd_t c);
    return (c.ctrl <= 3'd4) ? alu_ref(c.op1, c.op2, c.ctrl) : '0;
  endfunction

  always_comb i_alu_data = alu_ref(o_alu_op1, o_alu_op2, o_alu_ctrl);

  // Drive one cycle of inputs, advance the model across the edge, settle.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [CTRL_W-1:0] c, input logic rdy, input logic rst_n);
    cmd_t h;
    bit   cap, acc;
    i_cmd_valid = v;
    i_cmd_op1   = a;
    i_cmd_op2   = b;
    i_cmd_ctrl  = c;
    i_res_ready = rdy;
    i_rst_n     = rst_n;
    @(posedge i_clk);
    if (!rst_n) begin
      m_q.delete();
      m_v = 1'b0; m_data = '0; m_ctrl = '0; m_err = 1'b0;
    end else begin
      cap = (m_q.size() > 0) && (!m_v || rdy);
      acc = v && (m_q.size() < DEPTH);
      if (cap) begin
        h = m_q.pop_front();
        m_v = 1'b1; m_ctrl = h.ctrl; m_data = exp_result(h); m_err = (h.ctrl > 3'd4);
      end else if (m_v && rdy) begin
        m_v = 1'b0;
      end
      if (acc) m_q.push_back('{op1: a, op2: b, ctrl: c});
    end
    #1;
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, '0, '0, '0, rdy, 1'b1);
  endtask

  task automatic test_reset();
    cycle(1'b1, 4'h3, 4'h3, 3'd0, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b0);
    nvec++; if (o_res_valid !== 1'b0) begin nfail++; $display("FAIL reset_valid: got %0b want 0", o_res_valid); end
    nvec++; if (o_res_data !== 8'h00) begin nfail++; $display("FAIL reset_data: got %0h want 00", o_res_data); end
    nvec++; if (o_res_ctrl !== 3'd0 || o_res_err !== 1'b0) begin nfail++; $display("FAIL reset_ctrl_err: got %0d/%0b want 0/0", o_res_ctrl, o_res_err); end
    nvec++; if (o_level !== '0 || o_cmd_ready !== 1'b1) begin nfail++; $display("FAIL reset_fifo: level %0d ready %0b want 0/1", o_level, o_cmd_ready); end
    nvec++; if (o_alu_op1 !== '0 || o_alu_op2 !== '0 || o_alu_ctrl !== '0) begin nfail++; $display("FAIL reset_alu: got %0h %0h %0d want 0 0 0", o_alu_op1, o_alu_op2, o_alu_ctrl); end
    idle(1'b1);
  endtask

  task automatic test_add();
    cycle(1'b1, 4'd3, 4'd5, OP_ADD, 1'b1, 1'b1);
    nvec++; if (o_res_valid !== 1'b0) begin nfail++; $display("FAIL add_latency: valid %0b one edge after accept, want 0", o_res_valid); end
    nvec++; if (o_level !== LW'(1) || o_alu_op1 !== 4'd3 || o_alu_op2 !== 4'd5 || o_alu_ctrl !== OP_ADD) begin
      nfail++; $display("FAIL add_head: level %0d alu %0h %0h %0d want 1 3 5 0", o_level, o_alu_op1, o_alu_op2, o_alu_ctrl); end
    idle(1'b1);
    nvec++; if (o_res_valid !== 1'b1 || o_res_data !== 8'h08 || o_res_err !== 1'b0) begin
      nfail++; $display("FAIL add_result: valid %0b data %0h err %0b want 1 08 0", o_res_valid, o_res_data, o_res_err); end
    idle(1'b1);
    nvec++; if (o_res_valid !== 1'b0 || o_res_data !== 8'h08) begin
      nfail++; $display("FAIL add_drain: valid %0b data %0h want 0 08", o_res_valid, o_res_data); end
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, 4'hF, 4'hF, OP_MUL, 1'b1, 1'b1);
    cycle(1'b1, 4'h9, 4'h9, OP_ADD, 1'b1, 1'b1);
    nvec++; if (o_res_valid !== 1'b1 || o_res_data !== 8'hE1 || o_res_ctrl !== OP_MUL) begin
      nfail++; $display("FAIL b2b_mul: valid %0b data %0h ctrl %0d want 1 e1 2", o_res_valid, o_res_data, o_res_ctrl); end
    idle(1'b1);
    nvec++; if (o_res_valid !== 1'b1 || o_res_data !== 8'h02 || o_res_ctrl !== OP_ADD) begin
      nfail++; $display("FAIL b2b_add: valid %0b data %0h ctrl %0d want 1 02 0", o_res_valid, o_res_data, o_res_ctrl); end
    idle(1'b1);
    nvec++; if (o_res_valid !== 1'b0) begin nfail++; $display("FAIL b2b_drain: valid %0b want 0", o_res_valid); end
  endtask

  task automatic test_sub_nand();
    cycle(1'b1, 4'd2, 4'd5, OP_SUB, 1'b1, 1'b1);
    idle(1'b1);
    nvec++; if (o_res_data !== 8'h0D || o_res_valid !== 1'b1) begin nfail++; $display("FAIL sub_underflow: data %0h valid %0b want 0d 1", o_res_data, o_res_valid); end
    cycle(1'b1, 4'hF, 4'hF, OP_NAND, 1'b1, 1'b1);
    idle(1'b1);
    nvec++; if (o_res_data !== 8'h00 || o_res_ctrl !== OP_NAND || o_res_valid !== 1'b1) begin
      nfail++; $display("FAIL nand: data %0h ctrl %0d valid %0b want 00 3 1", o_res_data, o_res_ctrl, o_res_valid); end
    idle(1'b1);
  endtask

  task automatic test_backpressure();
    cmd_t cmds[6];
    logic [2*WIDTH-1:0] got[$];
    bit pending;
    int k;
    for (int i = 0; i < 6; i++) begin
      cmds[i] = '{op1: WIDTH'($urandom), op2: WIDTH'($urandom), ctrl: 3'($urandom_range(0, 4))};
      if (i < 5) cycle(1'b1, cmds[i].op1, cmds[i].op2, cmds[i].ctrl, 1'b0, 1'b1);
    end
    // Sixth command is presented but must stall while the FIFO is full.
    cycle(1'b1, cmds[5].op1, cmds[5].op2, cmds[5].ctrl, 1'b0, 1'b1);
    nvec++; if (o_level !== LW'(4) || o_cmd_ready !== 1'b0 || o_res_valid !== 1'b1) begin
      nfail++; $display("FAIL bp_full: level %0d ready %0b valid %0b want 4 0 1", o_level, o_cmd_ready, o_res_valid); end
    pending = 1'b1;
    k = 0;
    while (got.size() < 6 && k < 40) begin
      if (k == 0) begin
        nvec++; if (o_cmd_ready !== 1'b0) begin nfail++; $display("FAIL bp_ready_early: ready %0b want 0", o_cmd_ready); end
      end
      if (k == 1) begin
        nvec++; if (o_cmd_ready !== 1'b1) begin nfail++; $display("FAIL bp_ready_return: ready %0b want 1", o_cmd_ready); end
      end
      if (o_res_valid) got.push_back(o_res_data);
      if (pending && m_q.size() < DEPTH) begin
        cycle(1'b1, cmds[5].op1, cmds[5].op2, cmds[5].ctrl, 1'b1, 1'b1);
        pending = 1'b0;
      end else begin
        cycle(pending, cmds[5].op1, cmds[5].op2, cmds[5].ctrl, 1'b1, 1'b1);
      end
      k++;
    end
    nvec++; if (got.size() != 6) begin nfail++; $display("FAIL bp_count: got %0d results want 6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      nvec++; if (got[i] !== exp_result(cmds[i])) begin
        nfail++; $display("FAIL bp_order[%0d]: got %0h want %0h", i, got[i], exp_result(cmds[i])); end
    end
    idle(1'b1);
  endtask

  task automatic test_illegal();
    cycle(1'b1, 4'd7, 4'd1, 3'd6, 1'b1, 1'b1);
    idle(1'b1);
    nvec++; if (o_res_data !== 8'h00 || o_res_err !== 1'b1 || o_res_ctrl !== 3'd6 || o_res_valid !== 1'b1) begin
      nfail++; $display("FAIL illegal: data %0h err %0b ctrl %0d valid %0b want 00 1 6 1", o_res_data, o_res_err, o_res_ctrl, o_res_valid); end
    cycle(1'b1, 4'd1, 4'd1, OP_ADD, 1'b1, 1'b1);
    idle(1'b1);
    nvec++; if (o_res_err !== 1'b0 || o_res_data !== 8'h02) begin
      nfail++; $display("FAIL illegal_clear: err %0b data %0h want 0 02", o_res_err, o_res_data); end
    idle(1'b1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'(i + 1), 4'd2, OP_MUL, 1'b0, 1'b1);
    nvec++; if (o_level !== LW'(3) || o_res_valid !== 1'b1) begin
      nfail++; $display("FAIL rstmid_pre: level %0d valid %0b want 3 1", o_level, o_res_valid); end
    cycle(1'b1, 4'd5, 4'd5, OP_ADD, 1'b1, 1'b0);
    nvec++; if (o_res_valid !== 1'b0 || o_level !== '0 || o_cmd_ready !== 1'b1 || o_alu_ctrl !== '0 || o_res_data !== '0) begin
      nfail++; $display("FAIL rstmid: valid %0b level %0d ready %0b alu_ctrl %0d data %0h want 0 0 1 0 00",
                        o_res_valid, o_level, o_cmd_ready, o_alu_ctrl, o_res_data); end
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      nvec++; if (o_res_valid !== 1'b0 || o_level !== '0) begin
        nfail++; $display("FAIL rstmid_stale[%0d]: valid %0b level %0d want 0 0", i, o_res_valid, o_level); end
    end
  endtask

  task automatic test_random();
    logic [2*WIDTH-1:0] ea;
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0), WIDTH'($urandom), WIDTH'($urandom), 3'($urandom),
            ($urandom_range(0, 2) != 0), 1'b1);
      nvec++; if (o_res_valid !== m_v || o_level !== LW'(m_q.size()) || o_cmd_ready !== (m_q.size() < DEPTH)) begin
        nfail++; $display("FAIL rand_ctl[%0d]: valid %0b level %0d ready %0b want %0b %0d %0b",
                          i, o_res_valid, o_level, o_cmd_ready, m_v, m_q.size(), (m_q.size() < DEPTH)); end
      nvec++; if (o_res_data !== m_data || o_res_ctrl !== m_ctrl || o_res_err !== m_err) begin
        nfail++; $display("FAIL rand_res[%0d]: data %0h ctrl %0d err %0b want %0h %0d %0b",
                          i, o_res_data, o_res_ctrl, o_res_err, m_data, m_ctrl, m_err); end
      ea = (m_q.size() > 0) ? {m_q[0].op1, m_q[0].op2} : '0;
      nvec++; if ({o_alu_op1, o_alu_op2} !== ea || o_alu_ctrl !== ((m_q.size() > 0) ? m_q[0].ctrl : 3'd0)) begin
        nfail++; $display("FAIL rand_alu[%0d]: ops %0h ctrl %0d want %0h", i, {o_alu_op1, o_alu_op2}, o_alu_ctrl, ea); end
    end
  endtask

  initial begin
    m_v = 1'b0; m_data = '0; m_ctrl = '0; m_err = 1'b0;
    test_reset();
    test_add();
    test_back_to_back();
    test_sub_nand();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Upstream feeder for the combinational ALU (ops ADD/SUB/MUL/NAND/NOR, ctrl 0..4).
- Accepts operand/opcode commands over a valid/ready handshake and buffers them in a small FIFO.
- Drives the FIFO head onto the ALU operand/ctrl inputs and captures the ALU result into a registered output slot.
- Presents the result downstream with its own valid/ready handshake.
- Decouples a bursty command source from a result consumer that can stall.

Parameters:
WIDTH, 4, operand width; ALU result width is 2*WIDTH.
DEPTH, 4, command FIFO entries; power of 2, minimum 2.

Ports:
i_clk  input  1  clock; all state updates on rising edge.
i_rst_n  input  1  reset, synchronous and active-low.
i_cmd_valid  input  1  command present.
o_cmd_ready  output  1  FIFO can accept; equals !full.
i_cmd_op1  input  WIDTH  operand 1.
i_cmd_op2  input  WIDTH  operand 2.
i_cmd_ctrl  input  3  opcode.
o_alu_op1  output  WIDTH  to ALU i_op1.
o_alu_op2  output  WIDTH  to ALU i_op2.
o_alu_ctrl  output  3  to ALU i_ctrl.
i_alu_data  input  2*WIDTH  from ALU o_data (combinational path).
o_res_valid  output  1  result slot full.
i_res_ready  input  1  consumer takes result.
o_res_data  output  2*WIDTH  registered result.
o_res_ctrl  output  3  opcode that produced o_res_data.
o_res_err  output  1  opcode was illegal (5..7).
o_level  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (i_rst_n low at edge): FIFO pointers and count = 0; o_res_valid = 0; o_res_data = 0; o_res_ctrl = 0; o_res_err = 0. Reset overrides all simultaneous push/pop/capture, including mid-burst; FIFO contents are discarded.
- Push: i_cmd_valid && o_cmd_ready at edge → write {op1, op2, ctrl} at wr_ptr, wr_ptr++ (wraps mod DEPTH). o_cmd_ready is derived from registered count only; there is no bypass when full, even if a pop occurs the same cycle.
- ALU drive, combinational from the FIFO head:
  - FIFO non-empty → o_alu_* = head entry.
  - FIFO empty → o_alu_op1/op2 = 0, o_alu_ctrl = 0.
- Capture condition: cap = !empty && (!o_res_valid || i_res_ready).
- On cap at edge:
  - Pop head; o_res_valid <= 1; o_res_ctrl <= head ctrl.
  - Legal ctrl (0..4): o_res_data <= i_alu_data; o_res_err <= 0.
  - Illegal ctrl (5..7): o_res_data <= 0; o_res_err <= 1.
- Drain: o_res_valid && i_res_ready && !cap → o_res_valid <= 0; data/ctrl/err hold their last values.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Output-slot state machine has 2 states:
  - EMPTY → FULL on cap.
  - FULL → FULL on i_res_ready && cap (back-to-back, throughput 1/cycle).
  - FULL → EMPTY on i_res_ready && !cap.
  - FULL holds when !i_res_ready.
- Latency: command accepted at edge N → o_res_valid high after edge N+1 when the slot is free (2-cycle minimum).
- Result width rules: for non-MUL ops the ALU zero-pads the upper WIDTH bits. ADD/SUB are modulo 2^WIDTH with no carry/borrow output. The sequencer passes data through unmodified.
- o_level = count, range 0..DEPTH.
- Full: count == DEPTH. Empty: count == 0.
- Ordering is strict FIFO; no command is dropped or duplicated under any handshake pattern.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_NAND=3, OP_NOR=4, OP_LAST=4.
  - Command struct/width constant CMD_W = 2*WIDTH+3.
  - Used by the ALU, this block, and the benches.
- One sub-module: alu_cmd_fifo (DEPTH x CMD_W synchronous FIFO with count, full/empty, same reset). Top level holds the output slot and the legality check.

Test Plan:
- ADD: push op1=3, op2=5, ctrl=0; i_res_ready=1 → o_res_valid 2 cycles after acceptance; o_res_data=8'h08, err=0.
- MUL/ADD wrap: push 15*15 (ctrl=2) then 9+9 (ctrl=0) back-to-back → results 8'hE1 then 8'h02 on consecutive cycles, in order.
- SUB underflow: push 2-5 (ctrl=1) → o_res_data=8'h0D. NAND 4'hF,4'hF (ctrl=3) → 8'h00.
- Backpressure: i_res_ready=0; push 6 commands every cycle → 1 in slot, 4 in FIFO, o_cmd_ready=0 with o_level=4. Then raise i_res_ready → 5 results in push order; the 6th push is only accepted once ready returns.
- Illegal opcode: push op1=7, op2=1, ctrl=6 → o_res_data=8'h00, o_res_err=1, o_res_ctrl=6. A following legal command clears err.
- Reset mid-operation: with 3 entries queued and o_res_valid=1, hold i_rst_n=0 for one edge → o_res_valid=0, o_level=0, o_cmd_ready=1, o_alu_ctrl=0. No stale result appears after release.
